// File: rtl/cmdencode.sv
// Command-frame transmitter: serializes one read/write bus request into a LEN..SYNC byte frame.
// Define CMDENCODE_CRC_EN to compute CRC-16/CCITT; otherwise the CRC bytes are sent as zero.
module cmdencode #(
  parameter logic [7:0]  SYNC_BYTE = 8'h7e,
  parameter logic [15:0] CRC_INIT  = 16'hffff
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_stb_i,
  input  logic        req_we_i,
  input  logic [5:0]  req_seq_i,
  input  logic [15:0] req_adr_i,
  input  logic [7:0]  req_dat_i,
  output logic        req_busy_o,
  output logic        req_drop_o,
  output logic [7:0]  tx_data,
  output logic        tx_avail,
  input  logic        tx_pull
);

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_LEN  = 4'd1,
    ST_HDR  = 4'd2,
    ST_ADH  = 4'd3,
    ST_ADL  = 4'd4,
    ST_DAT  = 4'd5,
    ST_CRH  = 4'd6,
    ST_CRL  = 4'd7,
    ST_SYN  = 4'd8
  } state_t;

  state_t      state_r, state_nxt_s;
  logic        we_r;
  logic [5:0]  seq_r;
  logic [15:0] adr_r;
  logic [7:0]  dat_r;
  logic [7:0]  tx_data_r, data_nxt_s;
  logic        tx_avail_r;
  logic        drop_r;
  logic        accept_s, pull_s;
  logic [15:0] crc_nxt_s;

  assign accept_s   = req_stb_i && (state_r == ST_IDLE);
  assign pull_s     = tx_avail_r && tx_pull;
  assign req_busy_o = (state_r != ST_IDLE);
  assign req_drop_o = drop_r;
  assign tx_data    = tx_data_r;
  assign tx_avail   = tx_avail_r;

`ifdef CMDENCODE_CRC_EN
  logic [15:0] crc_r;

  function automatic logic [15:0] crc16_byte(input logic [15:0] crc, input logic [7:0] data);
    logic [15:0] c;
    c = crc ^ {data, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ 16'h1021) : (c << 1);
    end
    return c;
  endfunction

  // CRC value after the byte being pulled now (payload states only)
  always_comb begin
    crc_nxt_s = crc_r;
    if (pull_s && (state_r inside {ST_LEN, ST_HDR, ST_ADH, ST_ADL, ST_DAT})) begin
      crc_nxt_s = crc16_byte(crc_r, tx_data_r);
    end else begin
      crc_nxt_s = crc_r;
    end
  end

  // CRC register, seeded on every accepted request
  always_ff @(posedge clk) begin
    if (rst) begin
      crc_r <= CRC_INIT;
    end else if (accept_s) begin
      crc_r <= CRC_INIT;
    end else begin
      crc_r <= crc_nxt_s;
    end
  end
`else
  assign crc_nxt_s = CRC_INIT & 16'h0000;
`endif

  // Next-state logic: advance one byte per accepted pull
  always_comb begin
    state_nxt_s = state_r;
    if (state_r == ST_IDLE) begin
      if (req_stb_i) begin
        state_nxt_s = ST_LEN;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else if (pull_s) begin
      case (state_r)
        ST_LEN:  state_nxt_s = ST_HDR;
        ST_HDR:  state_nxt_s = ST_ADH;
        ST_ADH:  state_nxt_s = ST_ADL;
        ST_ADL:  state_nxt_s = we_r ? ST_DAT : ST_CRH;
        ST_DAT:  state_nxt_s = ST_CRH;
        ST_CRH:  state_nxt_s = ST_CRL;
        ST_CRL:  state_nxt_s = ST_SYN;
        ST_SYN:  state_nxt_s = ST_IDLE;
        default: state_nxt_s = ST_IDLE;
      endcase
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Byte for the next cycle; LEN comes straight from the strobe since holding regs load in parallel
  always_comb begin
    data_nxt_s = tx_data_r;
    if (accept_s) begin
      data_nxt_s = req_we_i ? 8'd8 : 8'd7;
    end else if (pull_s) begin
      case (state_nxt_s)
        ST_HDR:  data_nxt_s = {1'b1, we_r, seq_r};
        ST_ADH:  data_nxt_s = adr_r[15:8];
        ST_ADL:  data_nxt_s = adr_r[7:0];
        ST_DAT:  data_nxt_s = dat_r;
        ST_CRH:  data_nxt_s = crc_nxt_s[15:8];
        ST_CRL:  data_nxt_s = crc_nxt_s[7:0];
        ST_SYN:  data_nxt_s = SYNC_BYTE;
        default: data_nxt_s = 8'h00;
      endcase
    end else begin
      data_nxt_s = tx_data_r;
    end
  end

  // State and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      tx_data_r  <= 8'h00;
      tx_avail_r <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      tx_data_r  <= data_nxt_s;
      tx_avail_r <= (state_nxt_s != ST_IDLE);
      drop_r     <= req_stb_i && (state_r != ST_IDLE);
    end
  end

  // Request holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      we_r  <= 1'b0;
      seq_r <= 6'd0;
      adr_r <= 16'h0000;
      dat_r <= 8'h00;
    end else if (accept_s) begin
      we_r  <= req_we_i;
      seq_r <= req_seq_i;
      adr_r <= req_adr_i;
      dat_r <= req_dat_i;
    end else begin
      we_r  <= we_r;
      seq_r <= seq_r;
      adr_r <= adr_r;
      dat_r <= dat_r;
    end
  end

endmodule

// File: tb/tb_cmdencode.sv
// Self-checking bench for cmdencode: directed frames plus randomized requests against a byte-list model.
module tb_cmdencode;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_stb_i;
  logic        req_we_i;
  logic [5:0]  req_seq_i;
  logic [15:0] req_adr_i;
  logic [7:0]  req_dat_i;
  logic        req_busy_o;
  logic        req_drop_o;
  logic [7:0]  tx_data;
  logic        tx_avail;
  logic        tx_pull;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  cmdencode dut (
    .clk(clk), .rst(rst),
    .req_stb_i(req_stb_i), .req_we_i(req_we_i), .req_seq_i(req_seq_i),
    .req_adr_i(req_adr_i), .req_dat_i(req_dat_i),
    .req_busy_o(req_busy_o), .req_drop_o(req_drop_o),
    .tx_data(tx_data), .tx_avail(tx_avail), .tx_pull(tx_pull)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bit-at-a-time CRC-16/CCITT, init 0xFFFF
  function automatic logic [15:0] crc_model(input logic [7:0] bytes[$]);
    logic [15:0] crc;
    logic fb;
    crc = 16'hffff;
    foreach (bytes[k]) begin
      for (int i = 7; i >= 0; i--) begin
        fb  = crc[15] ^ bytes[k][i];
        crc = {crc[14:0], 1'b0};
        if (fb) crc = crc ^ 16'h1021;
      end
    end
    return crc;
  endfunction

  task automatic build_frame(input logic we, input logic [5:0] seq, input logic [15:0] adr,
                             input logic [7:0] dat);
    logic [7:0] p[$];
    logic [15:0] c;
    p = {};
    p.push_back(we ? 8'd8 : 8'd7);
    p.push_back({1'b1, we, seq});
    p.push_back(adr[15:8]);
    p.push_back(adr[7:0]);
    if (we) p.push_back(dat);
`ifdef CMDENCODE_CRC_EN
    c = crc_model(p);
`else
    c = 16'h0000;
`endif
    exp_q = p;
    exp_q.push_back(c[15:8]);
    exp_q.push_back(c[7:0]);
    exp_q.push_back(8'h7e);
  endtask

  // gap = pull every gap-th cycle; gap 0 = random pulls
  task automatic run_frame(input logic we, input logic [5:0] seq, input logic [15:0] adr,
                           input logic [7:0] dat, input int gap, input bit drop_mid,
                           input bit drop_syn);
    int idx, rel;
    bit pull, stb_prev, last;
    build_frame(we, seq, adr, dat);
    req_we_i = we; req_seq_i = seq; req_adr_i = adr; req_dat_i = dat;
    req_stb_i = 1'b1;
    @(posedge clk); #1;
    req_stb_i = 1'b0;
    req_we_i = 1'($urandom); req_seq_i = 6'($urandom);
    req_adr_i = 16'($urandom); req_dat_i = 8'($urandom);
    check("busy_after_stb", req_busy_o, 1);
    idx = 0; rel = 1;
    while (idx < exp_q.size() && rel < 300) begin
      check("avail", tx_avail, 1);
      check($sformatf("byte%0d", idx), tx_data, exp_q[idx]);
      pull = (gap == 0) ? 1'($urandom_range(0, 1)) : ((rel - 1) % gap == 0);
      last = pull && (idx == exp_q.size() - 1);
      tx_pull   = pull;
      req_stb_i = (drop_mid && rel == 3) || (drop_syn && last);
      stb_prev  = req_stb_i;
      @(posedge clk); #1;
      req_stb_i = 1'b0;
      tx_pull   = 1'b0;
      check("drop", req_drop_o, stb_prev);
      check("busy", req_busy_o, !last);
      if (pull) idx++;
      rel++;
    end
    check("frame_timeout", idx, exp_q.size());
    check("avail_end", tx_avail, 0);
  endtask

  initial begin
    logic [7:0] q[$];
    rst = 1'b1; req_stb_i = 1'b0; req_we_i = 1'b0; req_seq_i = 6'd0;
    req_adr_i = 16'h0000; req_dat_i = 8'h00; tx_pull = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_avail", tx_avail, 0);
    check("rst_data", tx_data, 8'h00);
    check("rst_busy", req_busy_o, 0);
    check("rst_drop", req_drop_o, 0);
    rst = 1'b0;

    q = {};
    for (int i = 0; i < 9; i++) q.push_back(8'h31 + 8'(i));
    check("crc_model_123456789", crc_model(q), 16'h29b1);

    // Directed read: 07 85 12 34 crc crc 7E
    build_frame(1'b0, 6'h05, 16'h1234, 8'h00);
    check("read_hdr_model", exp_q[1], 8'h85);
    run_frame(1'b0, 6'h05, 16'h1234, 8'h00, 1, 1'b0, 1'b0);
    // Directed write, continuous then backpressure
    run_frame(1'b1, 6'h3f, 16'habcd, 8'h5a, 1, 1'b0, 1'b0);
    run_frame(1'b1, 6'h3f, 16'habcd, 8'h5a, 4, 1'b0, 1'b0);
    // Drops at N+3 and at the SYN pull, then back-to-back strobe
    run_frame(1'b0, 6'h11, 16'h0f0f, 8'h00, 1, 1'b1, 1'b1);
    check("drop_at_syn_end", req_drop_o, 1);
    run_frame(1'b1, 6'h22, 16'h8001, 8'hc3, 1, 1'b0, 1'b0);

    // Pull while idle has no effect
    tx_pull = 1'b1;
    @(posedge clk); #1;
    tx_pull = 1'b0;
    check("idle_pull_avail", tx_avail, 0);
    check("idle_pull_busy", req_busy_o, 0);

    // Reset after ADH is pulled
    build_frame(1'b1, 6'h2a, 16'h5555, 8'h99);
    req_we_i = 1'b1; req_seq_i = 6'h2a; req_adr_i = 16'h5555; req_dat_i = 8'h99;
    req_stb_i = 1'b1;
    @(posedge clk); #1;
    req_stb_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check($sformatf("pre_rst_byte%0d", i), tx_data, exp_q[i]);
      tx_pull = 1'b1;
      @(posedge clk); #1;
      tx_pull = 1'b0;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_avail", tx_avail, 0);
    check("midrst_busy", req_busy_o, 0);
    check("midrst_data", tx_data, 8'h00);
    run_frame(1'b0, 6'h01, 16'h4321, 8'h00, 1, 1'b0, 1'b0);

    // Randomized requests
    for (int n = 0; n < 12; n++) begin
      run_frame(1'($urandom), 6'($urandom), 16'($urandom), 8'($urandom),
                int'($urandom_range(0, 4)), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/cmdencode.md
# cmdencode

Command-frame transmitter: serializes one host-style bus request (read or write, 16-bit address, 6-bit sequence) into the byte frame that the command parser accepts on a serial receive path. It sits in host-side bridges and loopback benches, feeding a UART or USB transmit byte stream. It is the encoder counterpart to the command parser on the device side.

## Interface

- `SYNC_BYTE`, default 8'h7e: frame trailer byte.
- `CRC_INIT`, default 16'hffff: CRC register value at frame start.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_stb_i`  in  1  one-cycle request strobe.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_seq_i`  in  6  sequence number.
- `req_adr_i`  in  16  bus address.
- `req_dat_i`  in  8  write data; ignored for reads.
- `req_busy_o`  out  1  frame in progress; strobes not accepted.
- `req_drop_o`  out  1  one-cycle pulse when a strobe arrives while busy.
- `tx_data`  out  8  current frame byte.
- `tx_avail`  out  1  `tx_data` valid.
- `tx_pull`  in  1  consumer takes `tx_data` this cycle (only meaningful while `tx_avail`).

## Operation

- Frame layout, in order:
  - LEN: total frame bytes. 7 for a read, 8 for a write.
  - HDR: `{1'b1, we, seq[5:0]}`.
  - ADR_HI.
  - ADR_LO.
  - DAT: write frames only.
  - CRC_HI.
  - CRC_LO.
  - SYNC (`SYNC_BYTE`).
- CRC definition:
  - CRC-16/CCITT: poly 0x1021, MSB-first, no reflection, no final XOR, init `CRC_INIT`.
  - Covers LEN through the last payload byte; excludes the CRC bytes and SYNC.
- Capture:
  - `req_stb_i` with `req_busy_o`=0 latches we/seq/adr/dat into holding registers.
  - Input ports may change after the strobe cycle without affecting the frame.
- FSM states: IDLE, LEN, HDR, ADH, ADL, DAT, CRH, CRL, SYN.
  - IDLE → LEN on an accepted strobe.
  - Each state advances on `tx_avail && tx_pull`.
  - ADL → DAT if we=1, else ADL → CRH.
  - SYN → IDLE.
- CRC update:
  - The CRC register is updated with the byte being pulled in states LEN through DAT.
  - It is loaded with `CRC_INIT` on an accepted strobe.
- Drop rule: `req_stb_i` while busy is ignored and pulses `req_drop_o` the next cycle. This includes the cycle in which SYN is pulled.
- Reset: returns to IDLE mid-frame and discards the partial frame. No resume.
- Reset values:
  - `tx_avail`=0, `tx_data`=8'h00.
  - `req_busy_o`=0, `req_drop_o`=0.
  - CRC register = `CRC_INIT`.

## Timing

- Strobe accepted at cycle N: `tx_avail`=1 and `tx_data`=LEN at N+1; `req_busy_o`=1 at N+1.
- Pull at cycle M: next byte on `tx_data` at M+1 with `tx_avail` held high. The consumer may pull every cycle, so a frame completes in 7 or 8 consecutive pulls.
- `tx_data` and `tx_avail` are registered outputs and hold steady while `tx_pull`=0 (backpressure of any length).
- After SYN is pulled at cycle M:
  - `tx_avail`=0 and `req_busy_o`=0 at M+1.
  - The earliest next accepted strobe is at M+1, giving a new LEN at M+2.
- Minimum frame period with a continuous pull: read 8 cycles, write 9 cycles, strobe to strobe.
- `tx_pull` while `tx_avail`=0 is ignored.

## Configuration

- `CMDENCODE_CRC_EN` defined: CRC computed as specified.
- Not defined:
  - CRC logic is removed.
  - CRC_HI and CRC_LO are transmitted as 8'h00.
  - Frame length, LEN value, and timing are unchanged.

## Test plan

- Read, CRC off, continuous pull: we=0, seq=0x05, adr=0x1234. Expect bytes 07 85 12 34 00 00 7E; `tx_avail` falls the cycle after 7E is pulled.
- Write, CRC on: we=1, seq=0x3F, adr=0xABCD, dat=0x5A. Expect 08 FF AB CD 5A, then CRC_HI/CRC_LO equal to a bit-serial model over those 5 bytes (model self-checked with "123456789" → 0x29B1), then 7E.
- Backpressure: pull only every 4th cycle on a write. Expect `tx_data` stable between pulls; byte sequence identical to the continuous case.
- Busy drop: strobe a second request at N+3 and again in the SYN-pull cycle. Expect a `req_drop_o` pulse after each and a single frame emitted.
- Back-to-back: strobe at the cycle after SYN is pulled. Expect LEN of the new frame one cycle later with no gap bytes.
- Reset mid-frame: assert `rst` after ADH is pulled. Expect `tx_avail`=0 and `req_busy_o`=0 next cycle; a new read then emits a complete fresh frame starting with 07.
